// File: rtl/fpu_issue_ctrl_if.sv
// Request, exception-checker, core and response signals of the FPU issue controller.
// The slave modport is the controller's view; master is the surrounding environment.
interface fpu_issue_ctrl_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  exc_op;
  logic [7:0]  exc_a;
  logic [7:0]  exc_b;
  logic        exc_flag;
  logic        core_start;
  logic [1:0]  core_op;
  logic [7:0]  core_a;
  logic [7:0]  core_b;
  logic        core_done;
  logic [7:0]  core_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic [1:0]  rsp_status;

  modport master (
    output req_valid, req_op, req_a, req_b, exc_flag, core_done, core_result, rsp_ready,
    input  req_ready, exc_op, exc_a, exc_b, core_start, core_op, core_a, core_b,
           rsp_valid, rsp_id, rsp_result, rsp_status
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, exc_flag, core_done, core_result, rsp_ready,
    output req_ready, exc_op, exc_a, exc_b, core_start, core_op, core_a, core_b,
           rsp_valid, rsp_id, rsp_result, rsp_status
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Two-requester round-robin issue controller for the shared 8-bit FPU datapath.
// Optional WAIT-state watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_issue_ctrl #(
`ifdef FPU_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 64,
`endif
  parameter logic [7:0]  QNAN        = 8'h7F
) (
  input  logic            clk,
  input  logic            rst,
  fpu_issue_ctrl_if.slave bus
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 2;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EXC     = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;
`ifdef FPU_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam int unsigned CNT_W     = 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rr_q;
  logic            id_q;
  logic [OPW-1:0]  op_q;
  logic [DW-1:0]   a_q, b_q;
  logic [DW-1:0]   res_q;
  logic [1:0]      sts_q;
  logic            any_valid_c, grant_c, accept_c, illegal_c;
`ifdef FPU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_c;
`endif

  // Pointer requester wins when valid, otherwise the other one.
  always_comb begin
    any_valid_c = |bus.req_valid;
    grant_c     = bus.req_valid[rr_q] ? rr_q : ~rr_q;
    accept_c    = (state_q == S_IDLE) && any_valid_c;
    illegal_c   = (op_q == 2'b11);
`ifdef FPU_TIMEOUT_EN
    tmo_c       = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_CHECK;
      S_CHECK: state_d = (illegal_c || bus.exc_flag) ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.core_done) state_d = S_RESP;
`ifdef FPU_TIMEOUT_EN
        else if (tmo_c)    state_d = S_RESP;
`endif
      end
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 2'b00;
    bus.core_start = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state_q)
      S_IDLE:  if (any_valid_c) bus.req_ready = 2'b01 << grant_c;
      S_ISSUE: bus.core_start = 1'b1;
      S_RESP:  bus.rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, arbitration pointer and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= 1'b0;
      id_q  <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      sts_q <= ST_OK;
`ifdef FPU_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      if (accept_c) begin
        rr_q <= ~grant_c;
        id_q <= grant_c;
        op_q <= grant_c ? bus.req_op[3:2] : bus.req_op[1:0];
        a_q  <= grant_c ? bus.req_a[15:8] : bus.req_a[7:0];
        b_q  <= grant_c ? bus.req_b[15:8] : bus.req_b[7:0];
      end
      if (state_q == S_CHECK) begin
        // Illegal opcode outranks whatever the checker reports.
        if (illegal_c) begin
          res_q <= QNAN;
          sts_q <= ST_ILLEGAL;
        end else if (bus.exc_flag) begin
          res_q <= QNAN;
          sts_q <= ST_EXC;
        end
      end
      if (state_q == S_WAIT) begin
        if (bus.core_done) begin
          res_q <= bus.core_result;
          sts_q <= ST_OK;
        end
`ifdef FPU_TIMEOUT_EN
        else if (tmo_c) begin
          res_q <= QNAN;
          sts_q <= ST_TIMEOUT;
        end
`endif
      end
`ifdef FPU_TIMEOUT_EN
      if (state_q == S_ISSUE)     cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
`endif
    end
  end

  assign bus.exc_op     = op_q;
  assign bus.exc_a      = a_q;
  assign bus.exc_b      = b_q;
  assign bus.core_op    = op_q;
  assign bus.core_a     = a_q;
  assign bus.core_b     = b_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_status = sts_q;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Two-requester issue controller for the shared 8-bit FPU datapath.
- Round-robin arbitrates requests, latches operands and drives the exception checker.
- Clean operations are dispatched to the arithmetic core through a start/done handshake. Excepted or illegal operations bypass the core and get a canonical NaN.
- Sits between the requesting units and the exception checker plus add/sub/mul core.

Parameters:
- QNAN, 8'h7F, result returned on exception/illegal/timeout (1-4-3 format, exp all ones, mantissa nonzero)
- TIMEOUT_CYC, 64, WAIT-state cycle limit; used only with FPU_TIMEOUT_EN

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  2  per-requester request valid
- REQ_READY  out  2  per-requester accept; at most one bit high
- REQ_OP  in  4  {op1[1:0], op0[1:0]}; 00 add, 01 sub, 10 mul, 11 illegal
- REQ_A  in  16  {A1, A0}
- REQ_B  in  16  {B1, B0}
- EXC_OP  out  2  operation presented to exception checker
- EXC_A  out  8  operand A to checker
- EXC_B  out  8  operand B to checker
- EXC_FLAG  in  1  checker result, combinational from EXC_*
- CORE_START  out  1  one-cycle dispatch pulse
- CORE_OP  out  2  latched op
- CORE_A  out  8  latched operand A
- CORE_B  out  8  latched operand B
- CORE_DONE  in  1  core completion pulse
- CORE_RESULT  in  8  valid while CORE_DONE=1
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response accept
- RSP_ID  out  1  requester index of response
- RSP_RESULT  out  8  result
- RSP_STATUS  out  2  00 OK, 01 EXCEPTION, 10 TIMEOUT, 11 ILLEGAL_OP

Behaviour:
- One clock CLK. RST is synchronous, active-high.
- Reset values:
  - state IDLE; rr pointer favours requester 0
  - REQ_READY=0, CORE_START=0, RSP_VALID=0
  - RSP_ID=0, RSP_RESULT=0, RSP_STATUS=00
  - latched op/A/B = 0, so EXC_*/CORE_* = 0
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = pointer requester if its REQ_VALID is set, otherwise the other requester if valid.
  - REQ_READY[grant]=1 combinationally.
  - On accept (cycle t): latch op/A/B/ID; pointer := other requester; go to CHECK.
- CHECK (t+1):
  - EXC_* driven from the latched registers; EXC_FLAG sampled at the end of the cycle.
  - op==11 -> RESP, ILLEGAL_OP, QNAN. Illegal takes priority over EXC_FLAG.
  - else EXC_FLAG=1 -> RESP, EXCEPTION, QNAN.
  - else -> ISSUE.
- ISSUE (t+2): CORE_START=1 for exactly this cycle; go to WAIT.
- WAIT:
  - CORE_DONE is sampled only here, so done in the ISSUE cycle is ignored.
  - On CORE_DONE: latch CORE_RESULT, status OK, go to RESP.
- RESP:
  - RSP_VALID=1; RSP_* held stable until RSP_READY.
  - On RSP_VALID&RSP_READY go to IDLE. The next request can be accepted the cycle after.
- Minimum latency, accept to RSP_VALID:
  - exception/illegal: 2 cycles
  - clean op: 3 + core latency (core latency ≥1)
- EXC_* and CORE_* outputs are continuously the latched registers, stable in all non-IDLE states.
- Boundary conditions:
  - Both requesters valid: pointer wins; the other wins next. A single valid requester always wins regardless of pointer.
  - REQ_VALID dropping without accept is legal; nothing is latched.
  - CORE_DONE outside WAIT is ignored.
  - RSP_READY held low stalls indefinitely; no new accepts during the stall.
  - RST mid-operation returns to IDLE with reset values. A core operation in flight is abandoned; its later CORE_DONE is ignored (IDLE).

Optional Feature:
- Macro: FPU_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on WAIT entry, increments each WAIT cycle.
  - When counter reaches TIMEOUT_CYC without CORE_DONE: go to RESP with TIMEOUT, QNAN.
  - CORE_DONE in the same cycle as expiry wins (OK).
- Undefined: no counter; WAIT persists until CORE_DONE; status 10 is never produced.

Test Plan:
- Req0 add A=8'h38, B=8'h38, EXC_FLAG=0, core done 2 cycles after start with 8'h40 -> CORE_START one pulse at t+2; RSP_VALID at t+5; RSP_ID=0, RESULT=8'h40, STATUS=00.
- Req1 add A=8'h78, B=8'hF8, checker asserts EXC_FLAG -> no CORE_START; RSP_VALID at t+2; RESULT=8'h7F, STATUS=01.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1; RSP_ID sequence matches; each op latched correctly.
- Req0 op=2'b11 with EXC_FLAG forced 1 -> STATUS=11, RESULT=8'h7F, no CORE_START.
- RSP_READY held low 10 cycles with req1 valid -> RSP_* stable, REQ_READY=0 throughout; req1 accepted the cycle after the handshake.
- With FPU_TIMEOUT_EN, TIMEOUT_CYC=4, core never done -> STATUS=10 after 4 WAIT cycles. RST asserted in WAIT -> all outputs at reset values next cycle.
